stream_merge_rr: RTL and testbench

//  Downstream companion of the 1:2 demux: merges the two 100-bit demux output

---
 rtl/merge_pkg.sv | 27 ++
 rtl/rr_arbiter_2.sv | 48 ++++
 rtl/stream_merge_rr.sv | 108 ++++++++++
 tb/tb_stream_merge_rr.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/merge_pkg.sv
// ============================================================================
// Module : merge_pkg
// Brief  : Shared types and constants for the round-robin stream merge.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package merge_pkg;

    localparam int unsigned MERGE_DATA_W = 100;

    typedef logic [0:0] src_t;

    localparam src_t SRC_IN1 = 1'b0;
    localparam src_t SRC_IN2 = 1'b1;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IN1  = 2'b01;
    localparam logic [1:0] GNT_IN2  = 2'b10;

    function automatic src_t gnt_to_src(input logic [1:0] gnt);
        return gnt[1] ? SRC_IN2 : SRC_IN1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_2.sv
// ============================================================================
// Module : rr_arbiter_2
// Brief  : Two-requester round-robin arbiter with one-hot grant.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_2
    import merge_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    src_t last_q;
    src_t last_d;

    always_comb begin
        gnt    = GNT_NONE;
        last_d = last_q;
        if (en) begin
            unique case (req)
                2'b01:   gnt = GNT_IN1;
                2'b10:   gnt = GNT_IN2;
                2'b11:   gnt = (last_q == SRC_IN2) ? GNT_IN1 : GNT_IN2;
                default: gnt = GNT_NONE;
            endcase
            if (|req) begin
                last_d = gnt_to_src(gnt);
            end
        end
    end

    // Resetting to in2 makes in1 the first winner of a contended grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= SRC_IN2;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/stream_merge_rr.sv
// ============================================================================
// Module : stream_merge_rr
// Brief  : Round-robin 2:1 valid/ready stream merge with registered output.
//          Optional per-channel counters enabled by macro MERGE_STATS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_merge_rr
    import merge_pkg::*;
#(
    parameter int unsigned DATA_W = MERGE_DATA_W
`ifdef MERGE_STATS_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [DATA_W-1:0] in2_data,
    input  logic              in2_valid,
    output logic              in2_ready,
    output logic [DATA_W-1:0] out_data,
    output src_t              out_src,
    output logic              out_valid,
    input  logic              out_ready
`ifdef MERGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2
`endif
);

    logic [DATA_W-1:0] data_q, data_d;
    src_t              src_q, src_d;
    logic              valid_q, valid_d;

    logic              w_load_en;
    logic [1:0]        w_gnt;
    logic              w_xfer;

    assign w_load_en = !valid_q || out_ready;

    rr_arbiter_2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({in2_valid, in1_valid}),
        .en    (w_load_en),
        .gnt   (w_gnt)
    );

    // A grant is only issued to a requesting channel, so it doubles as the transfer strobe.
    assign in1_ready = w_gnt[0];
    assign in2_ready = w_gnt[1];
    assign w_xfer    = |w_gnt;

    always_comb begin
        data_d  = data_q;
        src_d   = src_q;
        valid_d = valid_q;
        if (w_xfer) begin
            data_d  = w_gnt[1] ? in2_data : in1_data;
            src_d   = gnt_to_src(w_gnt);
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            src_q   <= SRC_IN1;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            src_q   <= src_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_src   = src_q;
    assign out_valid = valid_q;

`ifdef MERGE_STATS_EN
    logic [CNT_W-1:0] cnt1_q, cnt2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt1_q <= '0;
            cnt2_q <= '0;
        end else begin
            cnt1_q <= cnt1_q + CNT_W'(w_gnt[0]);
            cnt2_q <= cnt2_q + CNT_W'(w_gnt[1]);
        end
    end

    assign cnt1 = cnt1_q;
    assign cnt2 = cnt2_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_merge_rr.sv
// ============================================================================
// Module : tb_stream_merge_rr
// Brief  : Directed + random bench for stream_merge_rr against a queue model.
//          Counter checks compiled in when MERGE_STATS_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_merge_rr;
    import merge_pkg::*;

    localparam int DW = 100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in1_data, in2_data;
    logic          in1_valid, in2_valid, out_ready;
    logic          in1_ready, in2_ready, out_valid;
    logic [DW-1:0] out_data;
    src_t          out_src;

    always #5 clk = ~clk;

`ifdef MERGE_STATS_EN
    logic [15:0]   cnt1, cnt2;
    logic [1:0]    w2_cnt1, w2_cnt2;
    logic          w2_in1_ready, w2_in2_ready, w2_out_valid;
    logic [DW-1:0] w2_out_data;
    src_t          w2_out_src;
`endif

    stream_merge_rr #(
        .DATA_W (DW)
`ifdef MERGE_STATS_EN
        , .CNT_W (16)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in2_data  (in2_data),
        .in2_valid (in2_valid),
        .in2_ready (in2_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MERGE_STATS_EN
        , .cnt1    (cnt1),
        .cnt2      (cnt2)
`endif
    );

`ifdef MERGE_STATS_EN
    stream_merge_rr #(.DATA_W(DW), .CNT_W(2)) dut_w2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_ready (w2_in1_ready),
        .in2_data  (in2_data),
        .in2_valid (in2_valid),
        .in2_ready (w2_in2_ready),
        .out_data  (w2_out_data),
        .out_src   (w2_out_src),
        .out_valid (w2_out_valid),
        .out_ready (out_ready),
        .cnt1      (w2_cnt1),
        .cnt2      (w2_cnt2)
    );
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference: the output register is a queue of at most one word {src, data}.
    logic [DW:0] q[$];
    int          last_g;
    int          exp_c1, exp_c2;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_g = 2;
        exp_c1 = 0;
        exp_c2 = 0;
    endtask

    task automatic drive(input bit v1, input logic [DW-1:0] d1, input bit v2,
                         input logic [DW-1:0] d2, input bit ordy);
        in1_valid = v1;
        in1_data  = d1;
        in2_valid = v2;
        in2_data  = d2;
        out_ready = ordy;
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    // One clock: check at the falling edge, then advance the model past the rising edge.
    task automatic step();
        int          ch;
        bit          pop;
        logic [DW:0] w1, w2;
        @(negedge clk);
        ch = 0;
        if (q.size() == 0 || out_ready) begin
            if (in1_valid && in2_valid) ch = (last_g == 1) ? 2 : 1;
            else if (in1_valid)         ch = 1;
            else if (in2_valid)         ch = 2;
        end
        chk("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0][DW-1:0]);
            chk("out_src", out_src, q[0][DW]);
        end
        chk("in1_ready", in1_ready, ch == 1);
        chk("in2_ready", in2_ready, ch == 2);
`ifdef MERGE_STATS_EN
        chk("cnt1", cnt1, exp_c1 % 65536);
        chk("cnt2", cnt2, exp_c2 % 65536);
        chk("cnt1_w2", w2_cnt1, exp_c1 % 4);
        chk("cnt2_w2", w2_cnt2, exp_c2 % 4);
`endif
        pop = (q.size() != 0) && out_ready;
        w1  = {1'b0, in1_data};
        w2  = {1'b1, in2_data};
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (ch == 1) begin q.push_back(w1); last_g = 1; exp_c1++; end
        if (ch == 2) begin q.push_back(w2); last_g = 2; exp_c2++; end
    endtask

    initial begin
        // Reset with in1 already offering 0xA5.
        rst_n = 1'b0;
        drive(1'b1, DW'('hA5), 1'b0, '0, 1'b1);
        model_reset();
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_src", out_src, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        step();
        chk("first_data", out_data, 128'hA5);
        chk("first_src", out_src, 1'b0);
        chk("first_valid", out_valid, 1'b1);

        // Both channels contending: grants must alternate.
        drive(1'b1, DW'(1), 1'b1, DW'(2), 1'b1);
        repeat (4) step();

        // Backpressure with changing input data, then release.
        drive(1'b1, DW'(5), 1'b1, DW'(6), 1'b0);
        repeat (3) begin
            step();
            drive(1'b1, rand_word(), 1'b1, rand_word(), 1'b0);
        end
        out_ready = 1'b1;
        repeat (2) step();

        // Only in2 valid: back-to-back, no bubbles.
        drive(1'b0, '0, 1'b1, DW'('h3C), 1'b1);
        repeat (4) step();

        // Asynchronous reset while the output is full.
        drive(1'b1, DW'(7), 1'b1, DW'(8), 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        model_reset();
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("postrst_src", out_src, 1'b0);
        chk("postrst_data", out_data, 128'h7);

`ifdef MERGE_STATS_EN
        // 5 in1 and 3 in2 transfers from a clean reset.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        drive(1'b1, DW'(9), 1'b0, '0, 1'b1);
        repeat (5) step();
        drive(1'b0, '0, 1'b1, DW'(10), 1'b1);
        repeat (3) step();
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        @(negedge clk);
        chk("cnt1_five", cnt1, 128'd5);
        chk("cnt2_three", cnt2, 128'd3);
        chk("cnt1_wrap", w2_cnt1, 128'd1);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 60), rand_word(),
                  ($urandom_range(0, 99) < 60), rand_word(),
                  ($urandom_range(0, 99) < 70));
            step();
        end
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
